sim_channel_delay_line: RTL



---
 rtl/sim_channel_delay_line.sv | 83 ++++++++
 1 files changed

// File: rtl/sim_channel_delay_line.sv
// Programmable-latency delay line for one valid/ready harness channel.
// Each buffered beat carries its own countdown; the head is released only once its countdown reaches zero.
module sim_channel_delay_line #(
    parameter int  WIDTH       = 64,
    parameter int  DEPTH       = 8,
    parameter int  MAX_LATENCY = 15,
    localparam int LAT_BITS    = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [LAT_BITS-1:0] cfg_latency,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_bits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_bits,
    output logic [OCC_W-1:0]    occupancy,
    output logic [31:0]         stall_cycles
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LAT_BITS-1:0] LAT_MAX = LAT_BITS'(MAX_LATENCY);

    logic [WIDTH-1:0]    mem_bits [DEPTH];
    logic [LAT_BITS-1:0] mem_cnt  [DEPTH];
    logic [WIDTH-1:0]    last_bits;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [31:0]         stall_q;
    logic [LAT_BITS-1:0] lat_in;
    logic                enq, deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready     = (occupancy < OCC_W'(DEPTH));
    assign out_valid    = (occupancy != '0) && (mem_cnt[rd_ptr] == '0);
    // When empty, keep showing the last beat taken so out_bits never goes stale-garbage or X.
    assign out_bits     = (occupancy == '0) ? last_bits : mem_bits[rd_ptr];
    assign enq          = in_valid && in_ready;
    assign deq          = out_valid && out_ready;
    assign lat_in       = (cfg_latency > LAT_MAX) ? LAT_MAX : cfg_latency;
    assign stall_cycles = stall_q;

    // Countdowns run in every slot; empty slots simply sit at zero and are rewritten on enqueue.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (wr_ptr == PTR_W'(i)))
                mem_cnt[i] <= lat_in;
            else if (mem_cnt[i] != '0)
                mem_cnt[i] <= mem_cnt[i] - LAT_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && enq)
            mem_bits[wr_ptr] <= in_bits;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            stall_q   <= '0;
            last_bits <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                last_bits <= mem_bits[rd_ptr];
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
            if (out_valid && !out_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end
endmodule
